torreta_disparo: RTL and testbench

TORRETA_DISPARO -- requirements
Module: torreta_disparo

---
 rtl/torreta_pkg.sv | 25 ++
 rtl/temporizador_disparo.sv | 36 +++
 rtl/torreta_disparo.sv | 183 ++++++++++++++++++
 tb/tb_torreta_disparo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/torreta_pkg.sv
// Shared state encoding and default timing constants for the firing turret.
package torreta_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PREPARA = 3'd1,
    DISPARA = 3'd2,
    RECARGA = 3'd3
  } estado_t;

  localparam int          M_MUNICAO_PADRAO   = 16;
  localparam int          N_MUNICAO_PADRAO   = 4;
  localparam int          T_PREPARA_PADRAO   = 200000;
  localparam int          T_DISPARO_PADRAO   = 200000;
  localparam int          T_RECARGA_PADRAO   = 200000;
  localparam int          N_RAJADA_PADRAO    = 3;
  localparam logic [11:0] DIST_AMEACA_PADRAO = 12'h050;

  function automatic int maior3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/temporizador_disparo.sv
// Shared state timer: counts while enabled, restarts on every state entry,
// and flags the last cycle of the current state.
module temporizador_disparo #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             conta,
  input  logic [WIDTH-1:0] limite,
  output logic             fim
);

  logic [WIDTH-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && (valor_q != limite)) begin
      valor_d = valor_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  // Deliberately independent of zera: zera is derived from the FSM, which uses fim.
  assign fim = conta && (valor_q == limite);

endmodule

// File: rtl/torreta_disparo.sv
// Turret firing controller: threat detection, ammunition bookkeeping and the
// OCIOSO/PREPARA/DISPARA/RECARGA sequence for single shots and bursts.
module torreta_disparo
  import torreta_pkg::*;
#(
  parameter int          M_MUNICAO   = M_MUNICAO_PADRAO,
  parameter int          N_MUNICAO   = N_MUNICAO_PADRAO,
  parameter int          T_PREPARA   = T_PREPARA_PADRAO,
  parameter int          T_DISPARO   = T_DISPARO_PADRAO,
  parameter int          T_RECARGA   = T_RECARGA_PADRAO,
  parameter int          N_RAJADA    = N_RAJADA_PADRAO,
  parameter logic [11:0] DIST_AMEACA = DIST_AMEACA_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          medida,
  input  logic                 medida_pronto,
  input  logic                 conta_municao,
  input  logic                 modo_rajada,
  input  logic                 disparar,
  input  logic                 cancelar,
  output logic                 ameaca_detectada,
  output logic                 ocupado,
  output logic                 gatilho,
  output logic                 fim_disparo,
  output logic                 fim_rajada,
  output logic                 erro_sem_municao,
  output logic [N_MUNICAO-1:0] contagem_municao,
  output logic                 municao_carregada,
  output logic [2:0]           db_estado
);

  localparam int                   T_MAX       = maior3(T_PREPARA, T_DISPARO, T_RECARGA);
  localparam int                   TW          = $clog2(T_MAX + 1);
  localparam int                   SW          = $clog2(N_RAJADA + 1);
  localparam logic [N_MUNICAO-1:0] MUNICAO_MAX = N_MUNICAO'(M_MUNICAO - 1);
  localparam logic [SW-1:0]        RAJADA      = SW'(N_RAJADA);

  estado_t              estado_q, estado_d;
  logic [SW-1:0]        tiros_q, tiros_d;
  logic [N_MUNICAO-1:0] municao_q, municao_d;
  logic                 modo_q, modo_d;
  logic                 ameaca_q, ameaca_d;
  logic                 conta_ant_q, conta_ant_d;
  logic                 fim_disparo_q, fim_disparo_d;
  logic                 fim_rajada_q, fim_rajada_d;
  logic                 erro_q, erro_d;
  logic                 decrementa, subida;
  logic [TW-1:0]        limite;
  logic                 fim_tempo, zera_tempo, conta_tempo;

  always_comb begin
    limite = '0;
    unique case (estado_q)
      PREPARA: limite = TW'(T_PREPARA - 1);
      DISPARA: limite = TW'(T_DISPARO - 1);
      RECARGA: limite = TW'(T_RECARGA - 1);
      default: limite = '0;
    endcase
  end

  assign conta_tempo = (estado_q != OCIOSO);
  assign zera_tempo  = (estado_d != estado_q);

  temporizador_disparo #(
    .WIDTH(TW)
  ) u_temporizador (
    .clock (clock),
    .reset (reset),
    .zera  (zera_tempo),
    .conta (conta_tempo),
    .limite(limite),
    .fim   (fim_tempo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      tiros_q       <= '0;
      municao_q     <= '0;
      modo_q        <= 1'b0;
      ameaca_q      <= 1'b0;
      conta_ant_q   <= 1'b0;
      fim_disparo_q <= 1'b0;
      fim_rajada_q  <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      tiros_q       <= tiros_d;
      municao_q     <= municao_d;
      modo_q        <= modo_d;
      ameaca_q      <= ameaca_d;
      conta_ant_q   <= conta_ant_d;
      fim_disparo_q <= fim_disparo_d;
      fim_rajada_q  <= fim_rajada_d;
      erro_q        <= erro_d;
    end
  end

  // An empty magazine is reported even without a threat; cancelar beats a timer expiry.
  always_comb begin
    estado_d      = estado_q;
    tiros_d       = tiros_q;
    modo_d        = modo_q;
    fim_disparo_d = 1'b0;
    fim_rajada_d  = 1'b0;
    erro_d        = 1'b0;
    decrementa    = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (disparar) begin
          if (municao_q == '0) begin
            erro_d = 1'b1;
          end else if (ameaca_q) begin
            estado_d = PREPARA;
            modo_d   = modo_rajada;
            tiros_d  = '0;
          end
        end
      end
      PREPARA: begin
        if (cancelar) begin
          estado_d     = OCIOSO;
          fim_rajada_d = (tiros_q != '0);
        end else if (fim_tempo) begin
          estado_d = DISPARA;
        end
      end
      DISPARA: begin
        if (fim_tempo) begin
          estado_d      = RECARGA;
          fim_disparo_d = 1'b1;
          decrementa    = 1'b1;
          tiros_d       = tiros_q + SW'(1);
        end
      end
      RECARGA: begin
        if (cancelar) begin
          estado_d     = OCIOSO;
          fim_rajada_d = (tiros_q != '0);
        end else if (fim_tempo) begin
          if (modo_q && (tiros_q < RAJADA) && (municao_q != '0)) begin
            estado_d = DISPARA;
          end else begin
            estado_d     = OCIOSO;
            fim_rajada_d = 1'b1;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // A reload edge on the same cycle as a shot cancels out, even when saturated.
  always_comb begin
    subida      = conta_municao && !conta_ant_q;
    conta_ant_d = conta_municao;
    municao_d   = municao_q;
    if (subida && !decrementa) begin
      if (municao_q != MUNICAO_MAX) begin
        municao_d = municao_q + N_MUNICAO'(1);
      end
    end else if (decrementa && !subida) begin
      if (municao_q != '0) begin
        municao_d = municao_q - N_MUNICAO'(1);
      end
    end
    ameaca_d = medida_pronto ? (medida < DIST_AMEACA) : ameaca_q;
  end

  always_comb begin
    ocupado           = (estado_q != OCIOSO);
    gatilho           = (estado_q == DISPARA);
    db_estado         = estado_q;
    ameaca_detectada  = ameaca_q;
    fim_disparo       = fim_disparo_q;
    fim_rajada        = fim_rajada_q;
    erro_sem_municao  = erro_q;
    contagem_municao  = municao_q;
    municao_carregada = (municao_q != '0);
  end

endmodule

// File: tb/tb_torreta_disparo.sv
// Self-checking bench for torreta_disparo: directed scenarios plus random
// traffic, compared every cycle against a phase/countdown reference model.
module tb_torreta_disparo;

  localparam int TP = 4;
  localparam int TD = 3;
  localparam int TR = 5;
  localparam int NR = 3;
  localparam int MM = 16;
  localparam int NM = 4;

  localparam int P_IDLE   = 0;
  localparam int P_PREP   = 1;
  localparam int P_FIRE   = 2;
  localparam int P_RELOAD = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   medida = '0;
  logic          medida_pronto = 1'b0;
  logic          conta_municao = 1'b0;
  logic          modo_rajada = 1'b0;
  logic          disparar = 1'b0;
  logic          cancelar = 1'b0;
  logic          ameaca_detectada, ocupado, gatilho, fim_disparo, fim_rajada;
  logic          erro_sem_municao, municao_carregada;
  logic [NM-1:0] contagem_municao;
  logic [2:0]    db_estado;

  int checks = 0;
  int errors = 0;

  int m_phase, m_left, m_shots, m_ammo;
  bit m_mode, m_threat, m_prev, m_fd, m_fr, m_err;

  torreta_disparo #(
    .M_MUNICAO  (MM),
    .N_MUNICAO  (NM),
    .T_PREPARA  (TP),
    .T_DISPARO  (TD),
    .T_RECARGA  (TR),
    .N_RAJADA   (NR),
    .DIST_AMEACA(12'h050)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .medida           (medida),
    .medida_pronto    (medida_pronto),
    .conta_municao    (conta_municao),
    .modo_rajada      (modo_rajada),
    .disparar         (disparar),
    .cancelar         (cancelar),
    .ameaca_detectada (ameaca_detectada),
    .ocupado          (ocupado),
    .gatilho          (gatilho),
    .fim_disparo      (fim_disparo),
    .fim_rajada       (fim_rajada),
    .erro_sem_municao (erro_sem_municao),
    .contagem_municao (contagem_municao),
    .municao_carregada(municao_carregada),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task modelReset;
    m_phase = P_IDLE; m_left = 0; m_shots = 0; m_ammo = 0;
    m_mode = 0; m_threat = 0; m_prev = 0; m_fd = 0; m_fr = 0; m_err = 0;
  endtask

  // One clock edge of the reference: each phase counts down its remaining cycles.
  task modelStep;
    bit rise, dec;
    int next_phase;
    dec = 0; m_fd = 0; m_fr = 0; m_err = 0;
    next_phase = m_phase;
    case (m_phase)
      P_IDLE: begin
        if (disparar) begin
          if (m_ammo == 0) m_err = 1;
          else if (m_threat) begin
            next_phase = P_PREP; m_left = TP; m_mode = modo_rajada; m_shots = 0;
          end
        end
      end
      P_PREP: begin
        if (cancelar) begin next_phase = P_IDLE; m_fr = (m_shots > 0); end
        else if (m_left == 1) begin next_phase = P_FIRE; m_left = TD; end
        else m_left--;
      end
      P_FIRE: begin
        if (m_left == 1) begin
          next_phase = P_RELOAD; m_left = TR; m_fd = 1; dec = 1; m_shots++;
        end else m_left--;
      end
      default: begin
        if (cancelar) begin next_phase = P_IDLE; m_fr = (m_shots > 0); end
        else if (m_left == 1) begin
          if (m_mode && m_shots < NR && m_ammo > 0) begin next_phase = P_FIRE; m_left = TD; end
          else begin next_phase = P_IDLE; m_fr = 1; end
        end else m_left--;
      end
    endcase
    rise = conta_municao && !m_prev;
    if (rise && !dec) m_ammo = (m_ammo < MM - 1) ? m_ammo + 1 : m_ammo;
    else if (dec && !rise && m_ammo > 0) m_ammo--;
    if (medida_pronto) m_threat = (medida < 12'h050);
    m_prev = conta_municao;
    m_phase = next_phase;
  endtask

  task checkAll;
    checkOutput("ameaca_detectada", 32'(ameaca_detectada), 32'(m_threat));
    checkOutput("ocupado", 32'(ocupado), 32'(m_phase != P_IDLE));
    checkOutput("gatilho", 32'(gatilho), 32'(m_phase == P_FIRE));
    checkOutput("fim_disparo", 32'(fim_disparo), 32'(m_fd));
    checkOutput("fim_rajada", 32'(fim_rajada), 32'(m_fr));
    checkOutput("erro_sem_municao", 32'(erro_sem_municao), 32'(m_err));
    checkOutput("contagem_municao", 32'(contagem_municao), 32'(m_ammo));
    checkOutput("municao_carregada", 32'(municao_carregada), 32'(m_ammo != 0));
    checkOutput("db_estado", 32'(db_estado), 32'(m_phase));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare.
  task applyStimulus(input logic [11:0] med, input logic pronto, input logic conta,
                     input logic rajada, input logic disp, input logic canc);
    medida = med; medida_pronto = pronto; conta_municao = conta;
    modo_rajada = rajada; disparar = disp; cancelar = canc;
    @(posedge clock);
    modelStep();
    @(negedge clock);
    checkAll();
  endtask

  task idle(input int n);
    repeat (n) applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task addRounds(input int n);
    repeat (n) begin
      applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    modelReset();
    @(negedge clock);
    checkAll();
    reset = 1'b0;

    // Single shot with a close threat and two rounds loaded.
    applyStimulus(12'h049, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("threat_049", 32'(ameaca_detectada), 32'd1);
    addRounds(2);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(15);
    checkOutput("single_count", 32'(contagem_municao), 32'd1);

    // Burst with two rounds runs dry after two shots.
    addRounds(1);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(25);
    checkOutput("burst_count", 32'(contagem_municao), 32'd0);

    // Empty magazine refuses the request.
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("erro_pulse", 32'(erro_sem_municao), 32'd1);
    checkOutput("erro_state", 32'(db_estado), 32'd0);
    idle(2);

    // Distance exactly at the threshold is not a threat.
    applyStimulus(12'h050, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("threat_050", 32'(ameaca_detectada), 32'd0);
    addRounds(1);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("no_threat_state", 32'(db_estado), 32'd0);

    addRounds(20);
    checkOutput("saturate", 32'(contagem_municao), 32'd15);

    // Reload edge on the decrement edge while saturated.
    applyStimulus(12'h049, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    applyStimulus(12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("inc_dec_fim", 32'(fim_disparo), 32'd1);
    checkOutput("inc_dec_count", 32'(contagem_municao), 32'd15);
    idle(8);

    // Cancel during PREPARA.
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("cancel_prep_state", 32'(db_estado), 32'd0);
    checkOutput("cancel_prep_rajada", 32'(fim_rajada), 32'd0);
    idle(2);

    // Cancel during DISPARA is ignored.
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    repeat (3) applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("cancel_fire_fim", 32'(fim_disparo), 32'd1);
    checkOutput("cancel_fire_count", 32'(contagem_municao), 32'd14);
    idle(8);

    // Asynchronous reset in the middle of DISPARA.
    applyStimulus(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    checkOutput("pre_reset_gatilho", 32'(gatilho), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_gatilho", 32'(gatilho), 32'd0);
    checkOutput("reset_count", 32'(contagem_municao), 32'd0);
    checkOutput("reset_ocupado", 32'(ocupado), 32'd0);
    modelReset();
    @(negedge clock);
    checkAll();
    reset = 1'b0;

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(12'($urandom_range(0, 12'h099)), ($urandom % 4) == 0,
                    ($urandom % 3) == 0, 1'($urandom), ($urandom % 6) == 0,
                    ($urandom % 20) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
